sc1_boot_ctrl: RTL and testbench

//   Boot sequencer for the sc1_cpu. Holds the CPU in reset for a power-on delay, then

---
 rtl/sc1_boot_pkg.sv | 26 ++
 rtl/sc1_byte_packer.sv | 43 ++++
 rtl/sc1_boot_ctrl.sv | 159 +++++++++++++++
 tb/tb_sc1_boot_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc1_boot_pkg.sv
// Shared types and constants for the sc1 boot sequencer: state encoding,
// instruction/byte widths and boot header size.
package sc1_boot_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = INSTR_W / BYTE_W;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned HDR_W          = HDR_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_POR   = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_CHK   = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
    } boot_state_t;

    // States in which the byte stream is consumed.
    function automatic logic accepts_bytes(input boot_state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_LOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/sc1_byte_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word; word_done
// pulses the cycle after the fourth byte, clear drops any partial word.
module sc1_byte_packer
    import sc1_boot_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [BYTE_W-1:0]  i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_word_done,
    output logic               o_last_c
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]   r_idx;
    logic [INSTR_W-1:0] r_word;
    logic               r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_word <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                r_idx <= '0;
            end else if (i_valid) begin
                r_word[{r_idx, 3'b000} +: BYTE_W] <= i_byte;
                r_idx  <= r_idx + IDX_W'(1);
                r_done <= o_last_c;
            end
        end
    end

    assign o_last_c    = (r_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_word      = r_word;
    assign o_word_done = r_done;

endmodule

// File: rtl/sc1_boot_ctrl.sv
// Boot sequencer: power-on hold, then loads instruction memory from a byte
// stream and releases CPU reset. Optional trailing checksum: BOOT_CHECKSUM_EN.
module sc1_boot_ctrl
    import sc1_boot_pkg::*;
#(
    parameter int unsigned DEPTH_I         = 8,
    parameter int unsigned RESET_TIMER_BIT = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               restart,
    output logic               imem_we,
    output logic [DEPTH_I-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_data,
    output logic               cpu_reset,
    output logic               busy,
    output logic               error
);

    localparam int unsigned CNT_W     = RESET_TIMER_BIT + 1;
    localparam int unsigned N_W       = HDR_W + 1;
    localparam int unsigned MAX_WORDS = 1 << DEPTH_I;

    boot_state_t        r_state;
    boot_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BYTE_W-1:0]  r_n_lo;
    logic [DEPTH_I-1:0] r_last;
    logic [DEPTH_I-1:0] r_addr;
    logic               r_rx_ready;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_error;

    logic               w_acc;
    logic               w_pk_valid;
    logic               w_pk_clear;
    logic               w_byte3;
    logic               w_final;
    logic               w_word_done;
    logic [INSTR_W-1:0] w_word;
    logic [HDR_W-1:0]   w_n;
    logic               w_n_zero;
    logic               w_n_big;

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t ST_AFTER_LOAD = ST_CHK;
    logic [BYTE_W-1:0] r_sum;
`else
    localparam boot_state_t ST_AFTER_LOAD = ST_RUN;
    logic r_final;
`endif

    assign w_acc      = rx_valid & r_rx_ready;
    assign w_n        = {rx_data, r_n_lo};
    assign w_n_zero   = (w_n == '0);
    assign w_n_big    = N_W'(w_n) > N_W'(MAX_WORDS);
    assign w_pk_clear = restart | (r_state != ST_LOAD);
`ifdef BOOT_CHECKSUM_EN
    assign w_pk_valid = w_acc & (r_state == ST_LOAD);
`else
    assign w_pk_valid = w_acc & (r_state == ST_LOAD) & ~r_final;
`endif
    // Fourth byte of the last word is being accepted.
    assign w_final    = w_pk_valid & w_byte3 & (r_addr == r_last);

    sc1_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_pk_clear),
        .i_valid     (w_pk_valid),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_last_c    (w_byte3)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_POR:  if (r_cnt[RESET_TIMER_BIT]) w_state_nxt = ST_HDR0;
            ST_HDR0: if (w_acc) w_state_nxt = ST_HDR1;
            ST_HDR1: begin
                if (w_acc) begin
                    if (w_n_zero)     w_state_nxt = ST_AFTER_LOAD;
                    else if (w_n_big) w_state_nxt = ST_ERROR;
                    else              w_state_nxt = ST_LOAD;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_LOAD: if (w_final) w_state_nxt = ST_CHK;
            ST_CHK:  if (w_acc) w_state_nxt = (rx_data == r_sum) ? ST_RUN : ST_ERROR;
`else
            // Leave in the write cycle so cpu_reset drops the cycle after it.
            ST_LOAD: if (r_final) w_state_nxt = ST_RUN;
`endif
            ST_RUN, ST_ERROR: ;
            default: w_state_nxt = ST_ERROR;
        endcase
        if (restart && (r_state != ST_POR)) w_state_nxt = ST_HDR0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_POR;
            r_cnt       <= '0;
            r_n_lo      <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_rx_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_ready  <= accepts_bytes(w_state_nxt);
            r_cpu_reset <= (w_state_nxt != ST_RUN);
            r_busy      <= (w_state_nxt != ST_RUN);
            r_error     <= (w_state_nxt == ST_ERROR);
            if (r_state == ST_POR) r_cnt <= r_cnt + CNT_W'(1);
            if ((r_state == ST_HDR0) && w_acc) r_n_lo <= rx_data;
            if ((r_state == ST_HDR1) && w_acc) r_last <= DEPTH_I'(w_n - HDR_W'(1));
            if (restart || (r_state == ST_HDR0) || (r_state == ST_HDR1))
                r_addr <= '0;
            else if (w_word_done)
                r_addr <= r_addr + DEPTH_I'(1);
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sum <= '0;
        else if (restart || (r_state == ST_HDR0) || (r_state == ST_HDR1))
            r_sum <= '0;
        else if (w_pk_valid)
            r_sum <= r_sum + rx_data;
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_final <= 1'b0;
        else
            r_final <= ~restart & (r_state == ST_LOAD) & (w_final | r_final);
    end
`endif

    assign rx_ready  = r_rx_ready;
    assign imem_we   = w_word_done;
    assign imem_addr = r_addr;
    assign imem_data = w_word;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign error     = r_error;

endmodule

// File: tb/tb_sc1_boot_ctrl.sv
// Directed bench for sc1_boot_ctrl with a short power-on hold (RESET_TIMER_BIT=4).
module tb_sc1_boot_ctrl;

    localparam int unsigned DEPTH_I = 8;
    localparam int unsigned RTB     = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        restart = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        cpu_reset;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  pay [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    always #5 clk = ~clk;

    sc1_boot_ctrl #(.DEPTH_I(DEPTH_I), .RESET_TIMER_BIT(RTB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .restart   (restart),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge at which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        rx_valid = 1'b0;
        repeat (gap) step();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        rdy = 1'b0;
        while (!rdy) begin
            rdy = rx_ready;
            step();
            n++;
            if (!rdy && n > 40) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: byte %02h not accepted within 40 cycles", b);
                rdy = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_payload(input int first, input int count, input int gap);
        for (int i = 0; i < count; i++) send_byte(pay[first + i], gap);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic wait_hdr0();
        int n;
        n = 0;
        while (rx_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({cpu_reset, busy, rx_ready, imem_we, error} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 11000", {cpu_reset, busy, rx_ready, imem_we, error});
        end
        checks++;
        if (imem_addr !== 8'h00 || imem_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h data %h required 0/0", imem_addr, imem_data);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
                errors++;
                $display("FAIL por_hold cycle %0d: got rx_ready %b cpu_reset %b required 0/1", i, rx_ready, cpu_reset);
            end
            step();
        end
        wait_hdr0();
        checks++;
        if ({rx_ready, cpu_reset, busy} !== 3'b111) begin
            errors++;
            $display("FAIL hdr0_entry: got rx_ready/cpu_reset/busy %b required 111", {rx_ready, cpu_reset, busy});
        end
    endtask

    task automatic test_load_basic();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_payload(0, 8, 0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_data !== 32'h88776655 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_write: got we %b addr %h data %h cpu_reset %b required 1/01/88776655/1",
                     imem_we, imem_addr, imem_data, cpu_reset);
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h64, 0);
`else
        step();
`endif
        checks++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_run: got cpu_reset %b busy %b we %b required 0/0/0", cpu_reset, busy, imem_we);
        end
        step();
        checks++;
        if (wr_data_q.size() !== 2 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h44332211) begin
            errors++;
            $display("FAIL basic_writes: got %0d writes, first %h@%h required 2, 44332211@00",
                     wr_data_q.size(), wr_data_q[0], wr_addr_q[0]);
        end
    endtask

    task automatic test_load_gaps();
        pulse_restart();
        checks++;
        if ({rx_ready, cpu_reset, busy} !== 3'b111) begin
            errors++;
            $display("FAIL restart_from_run: got rx_ready/cpu_reset/busy %b required 111", {rx_ready, cpu_reset, busy});
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        send_payload(0, 8, 2);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h64, 2);
`endif
        repeat (6) step();
        checks++;
        if (wr_data_q.size() !== 2 || wr_data_q[0] !== 32'h44332211 || wr_data_q[1] !== 32'h88776655 ||
            wr_addr_q[0] !== 8'd0 || wr_addr_q[1] !== 8'd1) begin
            errors++;
            $display("FAIL gap_writes: got %0d writes required 2 (44332211@00, 88776655@01)", wr_data_q.size());
        end
        checks++;
        if (cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL gap_run: got cpu_reset %b required 0", cpu_reset);
        end
    endtask

    task automatic test_zero_len();
        pulse_restart();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
        checks++;
        if (rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL zero_chk: got rx_ready %b cpu_reset %b required 1/1", rx_ready, cpu_reset);
        end
        send_byte(8'h00, 0);
`endif
        checks++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_run: got cpu_reset %b busy %b rx_ready %b required 0/0/0", cpu_reset, busy, rx_ready);
        end
        repeat (4) step();
        checks++;
        if (wr_data_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_writes: got %0d writes required 0", wr_data_q.size());
        end
    endtask

    task automatic test_too_long();
        pulse_restart();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        checks++;
        if ({error, cpu_reset, busy, rx_ready} !== 4'b1110) begin
            errors++;
            $display("FAIL n257_error: got error/cpu_reset/busy/rx_ready %b required 1110", {error, cpu_reset, busy, rx_ready});
        end
        pulse_restart();
        checks++;
        if (error !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL error_recover: got error %b rx_ready %b required 0/1", error, rx_ready);
        end
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        checks++;
        if (error !== 1'b0 || rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL n256_load: got error %b rx_ready %b cpu_reset %b required 0/1/1", error, rx_ready, cpu_reset);
        end
    endtask

    task automatic test_restart_mid();
        pulse_restart();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_payload(0, 6, 0);
        repeat (3) step();
        pulse_restart();
        checks++;
        if (rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL restart_mid_state: got rx_ready %b cpu_reset %b required 1/1", rx_ready, cpu_reset);
        end
        repeat (5) step();
        checks++;
        if (wr_data_q.size() !== 1 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h44332211) begin
            errors++;
            $display("FAIL restart_partial: got %0d writes required 1 (44332211@00)", wr_data_q.size());
        end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_data !== 32'hD4C3B2A1) begin
            errors++;
            $display("FAIL reload_word0: got we %b addr %h data %h required 1/00/D4C3B2A1", imem_we, imem_addr, imem_data);
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'hEA, 0);
`else
        step();
`endif
        checks++;
        if (cpu_reset !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reload_run: got cpu_reset %b error %b required 0/0", cpu_reset, error);
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        pulse_restart();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        send_byte(8'h0A, 0);
        checks++;
        if (cpu_reset !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL chk_good: got cpu_reset %b error %b required 0/0", cpu_reset, error);
        end
        pulse_restart();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        send_byte(8'h0B, 0);
        checks++;
        if (error !== 1'b1 || cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL chk_bad: got error %b cpu_reset %b rx_ready %b required 1/1/0", error, cpu_reset, rx_ready);
        end
        pulse_restart();
        checks++;
        if (error !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL chk_recover: got error %b rx_ready %b required 0/1", error, rx_ready);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic held;
        pulse_restart();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_payload(0, 3, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({cpu_reset, busy, rx_ready, imem_we, error} !== 5'b11000 || imem_addr !== 8'h00 || imem_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got ctrl %b addr %h data %h required 11000/00/00000000",
                     {cpu_reset, busy, rx_ready, imem_we, error}, imem_addr, imem_data);
        end
        step();
        reset = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) held = 1'b0;
            step();
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL por_restart: got early release %b required hold for 16 cycles", ~held);
        end
        wait_hdr0();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_data !== 32'h04030201) begin
            errors++;
            $display("FAIL post_reset_load: got we %b addr %h data %h required 1/00/04030201", imem_we, imem_addr, imem_data);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_zero_len();
        test_too_long();
        test_restart_mid();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_async_reset();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
